// File: rtl/puf_resp_collector.sv
// Steps the 16:1 PUF mux select through every arbiter, waits a settle window per
// select, samples the muxed bit and hands the assembled word downstream on valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; sel parked at 0, last word held on resp
// SETTLE  | mux input switched, counting down the settle window
// CAPTURE | one cycle: sample bit_in into shadow[sel], advance or deliver
// VALID   | resp_valid high, waiting for resp_ready
module puf_resp_collector #(
  parameter  int SEL_W         = 4,
  parameter  int SETTLE_CYCLES = 4,
  localparam int N_BITS        = 2 ** SEL_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_bit_in,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_busy,
  output logic [N_BITS-1:0] o_resp,
  output logic              o_resp_valid,
  input  logic              i_resp_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    VALID   = 2'd3
  } state_t;

  localparam logic [7:0]       LP_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LP_LAST   = SEL_W'(N_BITS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_busy;
  logic [SEL_W-1:0]  r_sel;
  logic [7:0]        r_cnt;
  logic [N_BITS-1:0] r_shadow;
  logic [N_BITS-1:0] r_resp;
  logic              r_resp_valid;

  logic              w_last;
  logic              w_accept;
  logic [N_BITS-1:0] w_shadow_new;

  // busy is registered alongside the state so it never glitches combinationally
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_start)      w_state_nxt = SETTLE;
        SETTLE:  if (r_cnt == 8'd0) w_state_nxt = CAPTURE;
        CAPTURE: w_state_nxt = w_last ? VALID : SETTLE;
        VALID:   if (w_accept)     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_last       = (r_sel == LP_LAST);
    w_accept     = (r_state == VALID) && r_resp_valid && i_resp_ready;
    w_shadow_new = r_shadow;
    w_shadow_new[r_sel] = i_bit_in;
  end

  // sel only moves on CAPTURE->SETTLE, VALID->IDLE, abort or reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel        <= '0;
      r_cnt        <= 8'd0;
      r_shadow     <= '0;
      r_resp       <= '0;
      r_resp_valid <= 1'b0;
    end else if (i_abort) begin
      r_sel        <= '0;
      r_cnt        <= 8'd0;
      r_shadow     <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sel <= '0;
          if (i_start) begin
            r_cnt    <= LP_RELOAD;
            r_shadow <= '0;
          end
        end
        SETTLE: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        end
        CAPTURE: begin
          r_shadow <= w_shadow_new;
          if (w_last) begin
            r_resp       <= w_shadow_new;
            r_resp_valid <= 1'b1;
          end else begin
            r_sel <= r_sel + 1'b1;
            r_cnt <= LP_RELOAD;
          end
        end
        VALID: begin
          if (w_accept) begin
            r_resp_valid <= 1'b0;
            r_sel        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sel        = r_sel;
  assign o_busy       = r_busy;
  assign o_resp       = r_resp;
  assign o_resp_valid = r_resp_valid;

endmodule

// File: tb/tb_puf_resp_collector.sv
// Scoreboarded bench for puf_resp_collector: a mux model feeds bit_in from a pattern,
// expected words are queued at start and compared at each valid/ready handshake.
module tb_puf_resp_collector;

  localparam int SETTLE    = 4;
  localparam int SPAN      = SETTLE + 1;
  localparam int RISE_EDGE = 16 * SPAN + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        resp_ready;
  logic        bit_in;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] resp;
  logic        resp_valid;

  logic [15:0] pattern;
  logic        glitch_en;
  logic        glitch_val;
  logic        glitch_bit;
  int          cyc_since;
  int          n_tests;
  int          n_fail;
  int          hs_count;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  puf_resp_collector #(.SEL_W(4), .SETTLE_CYCLES(SETTLE)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_abort      (abort),
    .i_bit_in     (bit_in),
    .o_sel        (sel),
    .o_busy       (busy),
    .o_resp       (resp),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready)
  );

  // mux model, or a glitching source that is only stable across capture edges
  assign bit_in = glitch_en ? glitch_bit : pattern[sel];

  always @(posedge clk) begin
    if (start) cyc_since <= 0;
    else       cyc_since <= cyc_since + 1;
  end

  always @(negedge clk) begin
    if (glitch_en)
      glitch_bit = (((cyc_since + 1) % SPAN) == 0) ? glitch_val : ~glitch_val;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      hs_count++;
      if (exp_q.size() == 0) chk("sb_empty_at_hs", 32'(exp_q.size()), 32'd1);
      else                   chk("resp", 32'(resp), 32'(exp_q.pop_front()));
    end
  end

  function automatic int exp_sel(input int n);
    return (n / SPAN > 15) ? 15 : n / SPAN;
  endfunction

  task automatic idle_chk(input logic [15:0] r);
    chk("idle_busy",  32'(busy),       32'd0);
    chk("idle_valid", 32'(resp_valid), 32'd0);
    chk("idle_sel",   32'(sel),        32'd0);
    chk("idle_resp",  32'(resp),       32'(r));
  endtask

  // Returns at the negedge after resp_valid first rises; rise edge is the first
  // clock edge (counted from the start edge 0) that samples resp_valid high.
  task automatic run(input logic [15:0] pat, input bit expect_hs, input int pulse_n);
    int n;
    int rise;
    pattern = pat;
    if (expect_hs) exp_q.push_back(pat);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n    = 0;
    rise = -1;
    while (n < 200) begin
      @(negedge clk);
      if (resp_valid) begin
        rise = n + 1;
        break;
      end
      chk("sel_step", 32'(sel), 32'(exp_sel(n)));
      @(posedge clk);
      n++;
      #1 start = (n == pulse_n);
    end
    start = 1'b0;
    chk("valid_rise_edge", 32'(rise), 32'(RISE_EDGE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_before;
    int k;
    int seen;
    n_tests    = 0;
    n_fail     = 0;
    hs_count   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    resp_ready = 1'b0;
    pattern    = 16'h0000;
    glitch_en  = 1'b0;
    glitch_val = 1'b0;
    glitch_bit = 1'b0;

    // reset with a start pulse riding on it
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("rst_sel",   32'(sel),        32'd0);
    chk("rst_resp",  32'(resp),       32'h0000);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 idle_chk(16'h0000);

    // full capture, ready held high
    resp_ready = 1'b1;
    run(16'hA5C3, 1'b1, -1);
    @(posedge clk); #1 idle_chk(16'hA5C3);

    // backpressure
    resp_ready = 1'b0;
    run(16'h8001, 1'b1, -1);
    hs_before = hs_count;
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp",  32'(resp),       32'h8001);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 idle_chk(16'h8001);
    chk("bp_one_hs", 32'(hs_count - hs_before), 32'd1);

    // abort mid-run at sel==7
    run(16'h1234, 1'b1, -1);
    @(posedge clk); #1 idle_chk(16'h1234);
    pattern = 16'hFFFF;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (sel != 4'd7 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_reach_sel7", 32'(sel), 32'd7);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    idle_chk(16'h1234);
    seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);

    // abort beats start in IDLE
    @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    idle_chk(16'h1234);

    // abort in VALID drops valid and keeps the undelivered word
    resp_ready = 1'b0;
    run(16'h0F0F, 1'b0, -1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    idle_chk(16'h0F0F);
    resp_ready = 1'b1;

    // start ignored while busy (at sel==3 and in VALID)
    resp_ready = 1'b0;
    hs_before  = hs_count;
    run(16'h3C5A, 1'b1, 16);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ign_valid", 32'(resp_valid), 32'd1);
    chk("ign_busy",  32'(busy),       32'd1);
    chk("ign_sel",   32'(sel),        32'd15);
    resp_ready = 1'b1;
    @(posedge clk); #1 idle_chk(16'h3C5A);
    repeat (10) @(posedge clk);
    #1 idle_chk(16'h3C5A);
    chk("ign_one_hs", 32'(hs_count - hs_before), 32'd1);

    // sampling point: bit_in glitches everywhere except across capture edges
    glitch_en  = 1'b1;
    glitch_val = 1'b1;
    run(16'hFFFF, 1'b1, -1);
    @(posedge clk); #1 idle_chk(16'hFFFF);
    glitch_val = 1'b0;
    run(16'h0000, 1'b1, -1);
    @(posedge clk); #1 idle_chk(16'h0000);
    glitch_en = 1'b0;

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_resp_collector.md
Name: puf_resp_collector

Overview:
- Sequential read-side companion to the 16:1 response multiplexer.
- Drives the 4-bit select bus through all 16 PUF arbiter outputs, waits a programmable settle time per select value, and samples the single muxed bit.
- Assembles the 16 sampled bits into one response word and presents it on a valid/ready handshake to the downstream challenge-response controller.

Parameters:
- N_BITS, 16, number of response bits collected; fixed to 2**SEL_W.
- SEL_W, 4, width of the select bus driven to the mux.
- SETTLE_CYCLES, 4, clock cycles waited after each select change before sampling; legal range 1..255.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a collection; honoured only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE from any state.
- bit_in  input  1  muxed response bit, from the mux output.
- sel  output  SEL_W  select driven to the mux.
- busy  output  1  high in SETTLE, CAPTURE and VALID.
- resp  output  N_BITS  assembled response; bit i = sample taken with sel==i.
- resp_valid  output  1  response available.
- resp_ready  input  1  downstream accepts resp.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything.
  - State goes to IDLE.
  - sel, resp, resp_valid, busy, settle counter and shadow register are all cleared to 0.
- States are IDLE, SETTLE, CAPTURE and VALID.
- IDLE:
  - sel=0, busy=0, resp_valid=0; resp holds the last delivered word.
  - start=1 loads settle counter = SETTLE_CYCLES-1, clears the shadow register, keeps sel=0, and moves to SETTLE.
- SETTLE:
  - Counter decrements each cycle; sel is held stable.
  - When counter==0, move to CAPTURE.
  - Dwell is exactly SETTLE_CYCLES cycles.
- CAPTURE (1 cycle):
  - shadow[sel] <= bit_in.
  - If sel==N_BITS-1: resp <= shadow with the new bit merged, resp_valid <= 1, move to VALID.
  - Otherwise: sel <= sel+1, counter reloaded to SETTLE_CYCLES-1, move to SETTLE.
- VALID:
  - resp and resp_valid are held stable until a cycle where resp_valid && resp_ready.
  - On that cycle, resp_valid <= 0 on the next edge and the state returns to IDLE; sel <= 0.
  - resp_ready is ignored in all other states.
- Latency, with start sampled at edge 0:
  - Capture of bit k occurs at edge (k+1)*(SETTLE_CYCLES+1).
  - resp_valid rises at edge 16*(SETTLE_CYCLES+1)+1. For SETTLE_CYCLES=4 this is edge 81.
  - If resp_ready is held high, the earliest next start is accepted 2 cycles after resp_valid rises.
- start outside IDLE is ignored: no restart and no queuing.
- abort:
  - In SETTLE or CAPTURE: return to IDLE, sel=0, resp unchanged, resp_valid stays 0, partial shadow discarded.
  - In VALID: resp_valid drops, resp keeps the undelivered word.
- Simultaneous events:
  - abort and start in the same IDLE cycle: abort wins and the state stays IDLE.
  - abort and resp_ready in VALID: the result is IDLE, same as normal acceptance.
- sel only changes on the CAPTURE→SETTLE transition, VALID→IDLE, or abort/reset. The mux input is never switched during a settle window.
- sel does not wrap: after bit N_BITS-1 it returns to 0 only via IDLE.
- busy equals (state != IDLE), registered with the state.

Test Plan:
- Reset then idle: assert rst 2 cycles, pulse start together with rst → sel=0, resp=16'h0000, resp_valid=0, busy=0; stays IDLE after rst falls.
- Full capture with SETTLE_CYCLES=4: model the mux so that bit_in = pattern[sel] with pattern=16'hA5C3, resp_ready=1, pulse start → resp_valid rises exactly 81 cycles after start, resp=16'hA5C3. sel steps 0..15 with each value held 5 cycles.
- Backpressure: pattern=16'h8001, resp_ready=0 for 20 cycles after valid → resp_valid and resp=16'h8001 stable throughout. Raise ready → one handshake, then IDLE next cycle.
- Abort mid-run: after a completed 16'h1234, start a new run and assert abort while sel==7 → IDLE next cycle, sel=0, resp still 16'h1234, resp_valid never asserted.
- start ignored while busy: pulse start at sel==3 and again in VALID → only one resp_valid pulse, sel sequence unbroken.
- Sampling point: toggle bit_in on the cycle after each CAPTURE (glitch during settle only) with stable value 1 at capture edges → resp=16'hFFFF; with stable value 0 at capture edges → resp=16'h0000.
